inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch unit for the 4-bit CPU. It holds a small program memory, sequences a program counter and presents one instruction per cycle: an opcode field of `W bits for the decoder and an immediate field of `W bits for the ALU data path. It sits upstream of the instruction decoder. It is the producer side of the `inst` interface that the decoder consumes.

Parameters:
AW, 4, program address width; memory depth = 2**AW entries
IW, 2*`W, instruction word width: {opcode[`W-1:0], imm[`W-1:0]}; fixed by `W, not overridden

Ports:
clk  in  1  system clock, rising edge
n_reset  in  1  asynchronous active-low reset
start  in  1  IDLE/HALT -> RUN request
clr  in  1  synchronous return to IDLE, pc cleared
halt  in  1  RUN -> HALT request
stall  in  1  freeze fetch for this cycle
jmp_en  in  1  redirect next fetch to jmp_addr
jmp_addr  in  AW  jump target
prog_we  in  1  program memory write strobe (honoured only in IDLE)
prog_addr  in  AW  program write address
prog_data  in  IW  program write data {opcode, imm}
inst  out  `W  opcode to decoder
imm  out  `W  immediate field
inst_valid  out  1  inst/imm hold a fetched instruction
pc  out  AW  address of the next fetch
busy  out  1  high while in RUN

Behaviour:
- Reset (n_reset low, asynchronous): state=IDLE, pc=0, inst=OP_NOP (0), imm=0, inst_valid=0, busy=0. Program memory is not reset.
- States: IDLE, RUN, HALT. Priority within a cycle: clr > halt > stall > jmp_en > sequential fetch.
- IDLE:
  - prog_we writes mem[prog_addr] <= prog_data at the clock edge.
  - start -> RUN with pc=0. inst and imm keep NOP/0; inst_valid=0.
  - If start and prog_we are both high, the write completes and start is also taken.
- RUN, no stall:
  - At each edge, inst/imm <= mem[pc] split as {op, imm}, pc <= pc+1 modulo 2**AW (15 -> 0), inst_valid=1.
  - The first valid instruction appears one edge after entering RUN.
- RUN, jmp_en without stall: inst/imm <= mem[jmp_addr], pc <= jmp_addr+1 (with wrap), inst_valid=1.
- RUN, stall: pc, inst, imm and inst_valid hold their values. jmp_en is ignored; the source must hold it until stall is low.
- halt in RUN: -> HALT. inst <= OP_NOP, imm <= 0, inst_valid <= 0, pc holds.
- HALT:
  - Outputs stay at NOP/invalid.
  - start -> RUN and resumes from the current pc; no re-fetch bubble beyond the normal one edge.
- clr from any state: -> IDLE, pc=0, inst=NOP, imm=0, inst_valid=0. Memory contents are kept.
- prog_we outside IDLE: ignored, memory unchanged.
- start in RUN: ignored. halt and stall in IDLE/HALT: ignored.
- busy = (state == RUN), driven from a register.
- The memory read is combinational from the address; the instruction lands in output registers, so inst is glitch-free for the decoder.

Decomposition:
- Shared defines header: `W, the OP_* opcode constants (OP_NOP=0 ... OP_MOV_B_A=6) and the SEL_* codes. These are shared with the decoder.
- State encoding is a local parameter set, 2 bits.
- One natural sub-module: inst_mem, an AW x IW register file with synchronous write and asynchronous read.

Test Plan:
1. Reset mid-RUN (n_reset low between edges at pc=5) -> outputs go to inst=0, imm=0, inst_valid=0, pc=0, busy=0 immediately, without waiting for a clock edge.
2. Load mem[0]=8'h35, mem[1]=8'h1A, mem[2]=8'h00, then pulse start -> successive edges give (inst,imm,pc) = (3,5,1), (1,A,2), (0,0,3), with inst_valid=1 from the first.
3. Load mem[15]=8'h42, mem[0]=8'h21, jump to 15 -> fetch (4,2) with pc=0, then (2,1) with pc=1 (wrap-around).
4. stall high for 3 cycles at pc=2 with jmp_en=1, jmp_addr=9 -> inst, imm and pc unchanged throughout. After stall falls with jmp_en still high -> mem[9] is fetched and pc=10.
5. halt at pc=6 -> inst=0, inst_valid=0, busy=0, pc=6. Then start -> mem[6] fetched, pc=7.
6. prog_we to addr 3 during RUN -> mem[3] unchanged when later fetched. clr -> IDLE with pc=0, and a reload to addr 3 then succeeds.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants for the 4-bit CPU front end: data width, opcodes, select codes,
// fetch state encoding and instruction-word field helpers.
package inst_fetch_pkg;

   localparam int W  = 4;
   localparam int IW = 2 * W;

   localparam logic [W-1:0] OP_NOP     = 4'd0;
   localparam logic [W-1:0] OP_LDA     = 4'd1;
   localparam logic [W-1:0] OP_LDB     = 4'd2;
   localparam logic [W-1:0] OP_ADD     = 4'd3;
   localparam logic [W-1:0] OP_SUB     = 4'd4;
   localparam logic [W-1:0] OP_MOV_A_B = 4'd5;
   localparam logic [W-1:0] OP_MOV_B_A = 4'd6;

   localparam logic [1:0] SEL_A   = 2'd0;
   localparam logic [1:0] SEL_B   = 2'd1;
   localparam logic [1:0] SEL_IMM = 2'd2;
   localparam logic [1:0] SEL_ALU = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   function automatic logic [W-1:0] op_of(input logic [IW-1:0] word);
      return word[IW-1:W];
   endfunction

   function automatic logic [W-1:0] imm_of(input logic [IW-1:0] word);
      return word[W-1:0];
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decoder bundle: registered instruction fields plus fetch status.
interface inst_fetch_if
   import inst_fetch_pkg::*;
#(
   parameter int AW = 4
);
   logic [W-1:0]  inst;
   logic [W-1:0]  imm;
   logic          inst_valid;
   logic [AW-1:0] pc;
   logic          busy;

   modport master (output inst, output imm, output inst_valid, output pc, output busy);
   modport slave  (input  inst, input  imm, input  inst_valid, input  pc, input  busy);
endinterface

// File: rtl/inst_fetch_mem.sv
// Program store: synchronous write, asynchronous read, contents survive reset.
module inst_mem #(
   parameter int AW = 4,
   parameter int IW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: sequences pc through program memory and registers one
// {opcode, imm} pair per cycle for the decoder.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          start,
   input  logic          clr,
   input  logic          halt,
   input  logic          stall,
   input  logic          jmp_en,
   input  logic [AW-1:0] jmp_addr,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   inst_fetch_if.master  o
);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [W-1:0]  inst_q, inst_d;
   logic [W-1:0]  imm_q, imm_d;
   logic          inst_valid_q, inst_valid_d;
   logic          busy_q, busy_d;

   logic          mem_we;
   logic [AW-1:0] rd_addr;
   logic [IW-1:0] rd_data;

   // A taken jump reads its target this same cycle, so the redirect costs no bubble.
   assign rd_addr = jmp_en ? jmp_addr : pc_q;

   inst_mem #(
      .AW (AW),
      .IW (IW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      imm_d        = imm_q;
      inst_valid_d = inst_valid_q;
      mem_we       = 1'b0;

      if (clr) begin
         state_d      = ST_IDLE;
         pc_d         = '0;
         inst_d       = OP_NOP;
         imm_d        = '0;
         inst_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               mem_we = prog_we;
               if (start) begin
                  state_d = ST_RUN;
                  pc_d    = '0;
               end
            end
            ST_RUN: begin
               if (halt) begin
                  state_d      = ST_HALT;
                  inst_d       = OP_NOP;
                  imm_d        = '0;
                  inst_valid_d = 1'b0;
               end else if (!stall) begin
                  inst_d       = op_of(rd_data);
                  imm_d        = imm_of(rd_data);
                  pc_d         = rd_addr + 1'b1;
                  inst_valid_d = 1'b1;
               end
            end
            ST_HALT: begin
               if (start) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d      = ST_IDLE;
               pc_d         = '0;
               inst_d       = OP_NOP;
               imm_d        = '0;
               inst_valid_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         inst_q       <= OP_NOP;
         imm_q        <= '0;
         inst_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         imm_q        <= imm_d;
         inst_valid_q <= inst_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign o.inst       = inst_q;
   assign o.imm        = imm_q;
   assign o.inst_valid = inst_valid_q;
   assign o.pc         = pc_q;
   assign o.busy       = busy_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios followed by random control traffic,
// each edge checked against a behavioural model of the fetch rules.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   logic       clk = 1'b0;
   logic       n_reset = 1'b1;
   logic       start = 1'b0, clr = 1'b0, halt = 1'b0, stall = 1'b0, jmp_en = 1'b0;
   logic [3:0] jmp_addr = '0;
   logic       prog_we = 1'b0;
   logic [3:0] prog_addr = '0;
   logic [7:0] prog_data = '0;

   always #5 clk = ~clk;

   inst_fetch_if #(.AW(4)) bus ();

   inst_fetch #(.AW(4)) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .start     (start),
      .clr       (clr),
      .halt      (halt),
      .stall     (stall),
      .jmp_en    (jmp_en),
      .jmp_addr  (jmp_addr),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .o         (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [13:0] exp_q[$];

   // Reference model: program image plus what the fetch unit should be showing.
   bit [7:0]   ref_mem [16];
   bit         running = 0, halted = 0;
   logic [3:0] ref_pc = 0, ref_inst = 0, ref_imm = 0;
   logic       ref_vld = 0;

   function automatic logic [13:0] dut_out();
      return {bus.inst, bus.imm, bus.inst_valid, bus.pc, bus.busy};
   endfunction

   function automatic logic [13:0] pack(input logic [3:0] i, input logic [3:0] m,
                                        input logic v, input logic [3:0] p, input logic b);
      return {i, m, v, p, b};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      running = 0; halted = 0;
      ref_pc = 0; ref_inst = 0; ref_imm = 0; ref_vld = 0;
   endtask

   task automatic model_edge();
      int a;
      if (clr) begin
         model_reset();
      end else if (!running && !halted) begin
         if (prog_we) ref_mem[prog_addr] = prog_data;
         if (start) begin
            running = 1;
            ref_pc  = 0;
         end
      end else if (running) begin
         if (halt) begin
            running = 0; halted = 1;
            ref_inst = 0; ref_imm = 0; ref_vld = 0;
         end else if (!stall) begin
            a = jmp_en ? int'(jmp_addr) : int'(ref_pc);
            ref_inst = 4'(ref_mem[a] / 16);
            ref_imm  = 4'(ref_mem[a] % 16);
            ref_pc   = 4'((a + 1) % 16);
            ref_vld  = 1;
         end
      end else if (start) begin
         running = 1; halted = 0;
      end
   endtask

   // Monitor: every registered output update is compared with the queued expectation.
   always @(negedge clk) begin
      logic [13:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("scoreboard", 16'(dut_out()), 16'(e));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      exp_q.push_back(pack(ref_inst, ref_imm, ref_vld, ref_pc, running));
      @(negedge clk);
      start = 0; clr = 0; halt = 0; stall = 0; jmp_en = 0; prog_we = 0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      prog_we = 1; prog_addr = a; prog_data = d;
      tick();
   endtask

   task automatic jmp(input logic [3:0] a);
      jmp_en = 1; jmp_addr = a;
      tick();
   endtask

   initial begin
      #1 n_reset = 0;
      #1 check("reset_state", 16'(dut_out()), 16'h0);
      @(negedge clk);
      n_reset = 1;

      for (int i = 0; i < 16; i++) wr(4'(i), 8'($urandom));
      wr(4'h3, 8'h77);
      wr(4'h5, 8'h5B);
      wr(4'h6, 8'h6D);

      // Basic sequential fetch
      wr(4'h0, 8'h35); wr(4'h1, 8'h1A); wr(4'h2, 8'h00);
      start = 1; tick();
      check("start_no_fetch", 16'(dut_out()), 16'(pack(4'h0, 4'h0, 1'b0, 4'h0, 1'b1)));
      tick(); check("seq0", 16'(dut_out()), 16'(pack(4'h3, 4'h5, 1'b1, 4'h1, 1'b1)));
      tick(); check("seq1", 16'(dut_out()), 16'(pack(4'h1, 4'hA, 1'b1, 4'h2, 1'b1)));
      tick(); check("seq2", 16'(dut_out()), 16'(pack(4'h0, 4'h0, 1'b1, 4'h3, 1'b1)));

      // Jump to the last address and wrap
      clr = 1; tick();
      wr(4'hF, 8'h42); wr(4'h0, 8'h21); wr(4'h9, 8'h9C);
      start = 1; tick();
      jmp(4'hF); check("jmp15", 16'(dut_out()), 16'(pack(4'h4, 4'h2, 1'b1, 4'h0, 1'b1)));
      tick();    check("wrap", 16'(dut_out()), 16'(pack(4'h2, 4'h1, 1'b1, 4'h1, 1'b1)));

      // Stall holds everything, pending jump taken once released
      tick();
      for (int i = 0; i < 3; i++) begin
         stall = 1; jmp_en = 1; jmp_addr = 4'h9;
         tick();
         check("stall_hold", 16'(dut_out()), 16'(pack(4'h1, 4'hA, 1'b1, 4'h2, 1'b1)));
      end
      jmp(4'h9); check("jmp_after_stall", 16'(dut_out()), 16'(pack(4'h9, 4'hC, 1'b1, 4'hA, 1'b1)));

      // Halt and resume from current pc
      jmp(4'h5);
      halt = 1; tick();
      check("halted", 16'(dut_out()), 16'(pack(4'h0, 4'h0, 1'b0, 4'h6, 1'b0)));
      start = 1; tick();
      tick(); check("resume", 16'(dut_out()), 16'(pack(4'h6, 4'hD, 1'b1, 4'h7, 1'b1)));

      // Writes outside IDLE are dropped; clr then reload works
      wr(4'h3, 8'hEE);
      jmp(4'h3); check("we_in_run_ignored", 16'(dut_out()), 16'(pack(4'h7, 4'h7, 1'b1, 4'h4, 1'b1)));
      clr = 1; tick(); check("clr", 16'(dut_out()), 16'h0);
      wr(4'h3, 8'hEE);
      start = 1; tick();
      jmp(4'h3); check("reload", 16'(dut_out()), 16'(pack(4'hE, 4'hE, 1'b1, 4'h4, 1'b1)));

      // Asynchronous reset between edges
      jmp(4'h4);
      check("pc_before_reset", 16'(bus.pc), 16'h5);
      #2 n_reset = 0;
      #1 check("async_reset", 16'(dut_out()), 16'h0);
      model_reset();
      #1 n_reset = 1;

      // Random control traffic
      for (int i = 0; i < 600; i++) begin
         clr       = ($urandom_range(0, 99) < 3);
         halt      = ($urandom_range(0, 99) < 6);
         stall     = ($urandom_range(0, 99) < 20);
         jmp_en    = ($urandom_range(0, 99) < 15);
         start     = ($urandom_range(0, 99) < 20);
         prog_we   = ($urandom_range(0, 99) < 30);
         jmp_addr  = 4'($urandom);
         prog_addr = 4'($urandom);
         prog_data = 8'($urandom);
         tick();
      end

      repeat (2) @(negedge clk);
      check("queue_drained", 16'(exp_q.size()), 16'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
